// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles every bus signal around the dmem arbiter: the cpu and aux request
// ports and the single-port dmem drive/return path.
//
//   cpu_* / aux_*   : req, wren, addr, wdata in; gnt, rvalid, rdata out
//   address_dmem    : dmem word address
//   data, wren      : dmem write data / write enable
//   q_dmem          : dmem read data (dmem runs on the inverted clock)
//
// slave  : the arbiter side
// master : the environment side (requesters plus the dmem instance)
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_wren;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              aux_req;
    logic              aux_wren;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_wdata;
    logic              aux_gnt;
    logic              aux_rvalid;
    logic [DATA_W-1:0] aux_rdata;

    logic [ADDR_W-1:0] address_dmem;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic [DATA_W-1:0] q_dmem;

    modport slave (
        input  cpu_req, cpu_wren, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  aux_req, aux_wren, aux_addr, aux_wdata,
        output aux_gnt, aux_rvalid, aux_rdata,
        output address_dmem, data, wren,
        input  q_dmem
    );

    modport master (
        output cpu_req, cpu_wren, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output aux_req, aux_wren, aux_addr, aux_wdata,
        input  aux_gnt, aux_rvalid, aux_rdata,
        input  address_dmem, data, wren,
        output q_dmem
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port dmem between the processor (cpu, fixed priority)
// and an auxiliary master (aux: loader/debug/DMA). A starvation counter
// forces one aux grant after MAX_WAIT consecutive denied aux cycles.
//
// Ports:
//   clock        : rising-edge master clock
//   reset        : synchronous, active-low
//   bus          : dmem_arbiter_if.slave (request ports + dmem drive)
//   aux_wait_cnt : current starvation count (probe)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    dmem_arbiter_if.slave                 bus,
    output logic [$clog2(MAX_WAIT+1)-1:0] aux_wait_cnt
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_FORCE  = 1'b1;

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]  w_wait_cnt_next;
    logic              w_cpu_gnt;
    logic              w_aux_gnt;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_wren;

    // Grant decision. While reset is low nothing is granted, so the dmem is
    // never written during reset.
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_aux_gnt = 1'b0;
        if (reset) begin
            if (r_state == ST_FORCE && bus.aux_req) begin
                w_aux_gnt = 1'b1;
            end else begin
                w_cpu_gnt = bus.cpu_req;
                w_aux_gnt = bus.aux_req & ~bus.cpu_req;
            end
        end
    end

    // Memory drive: the granted port owns the dmem, otherwise it sees zeros.
    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_wren  = 1'b0;
        if (w_cpu_gnt) begin
            w_addr  = bus.cpu_addr;
            w_wdata = bus.cpu_wdata;
            w_wren  = bus.cpu_wren;
        end else if (w_aux_gnt) begin
            w_addr  = bus.aux_addr;
            w_wdata = bus.aux_wdata;
            w_wren  = bus.aux_wren;
        end
    end

    // Starvation count saturates at MAX_WAIT; a grant or a dropped request
    // restarts it.
    always_comb begin
        w_wait_cnt_next = r_wait_cnt;
        if (w_aux_gnt || !bus.aux_req) begin
            w_wait_cnt_next = '0;
        end else if (r_wait_cnt != CNT_MAX) begin
            w_wait_cnt_next = r_wait_cnt + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state        <= ST_NORMAL;
            r_wait_cnt     <= '0;
            bus.cpu_rvalid <= 1'b0;
            bus.aux_rvalid <= 1'b0;
            bus.cpu_rdata  <= '0;
            bus.aux_rdata  <= '0;
        end else begin
            r_wait_cnt <= w_wait_cnt_next;
            // FORCE is entered on the edge where the count reaches MAX_WAIT
            // and always lasts a single cycle.
            r_state    <= (w_wait_cnt_next == CNT_MAX) ? ST_FORCE : ST_NORMAL;

            // dmem runs on the inverted clock, so q_dmem already holds the
            // data for this cycle's granted read.
            bus.cpu_rvalid <= w_cpu_gnt & ~bus.cpu_wren;
            bus.aux_rvalid <= w_aux_gnt & ~bus.aux_wren;
            if (w_cpu_gnt && !bus.cpu_wren) begin
                bus.cpu_rdata <= bus.q_dmem;
            end
            if (w_aux_gnt && !bus.aux_wren) begin
                bus.aux_rdata <= bus.q_dmem;
            end
        end
    end

    assign bus.cpu_gnt      = w_cpu_gnt;
    assign bus.aux_gnt      = w_aux_gnt;
    assign bus.address_dmem = w_addr;
    assign bus.data         = w_wdata;
    assign bus.wren         = w_wren;
    assign aux_wait_cnt     = r_wait_cnt;
endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed scenarios followed by randomized traffic, each cycle compared
// against a behavioural model of the arbitration rules and of the dmem
// contents. The bench also models the dmem itself on the falling edge.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] aux_wait_cnt;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clock       (clk),
        .reset       (rst_n),
        .bus         (bus),
        .aux_wait_cnt(aux_wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dmem: registered on the falling edge, read-before-write.
    logic [DATA_W-1:0] mem [1 << ADDR_W];
    always @(negedge clk) begin
        if (bus.wren) mem[bus.address_dmem] <= bus.data;
        bus.q_dmem <= mem[bus.address_dmem];
    end

    // Reference model state
    logic [DATA_W-1:0] shadow [1 << ADDR_W];
    int                m_cnt;
    bit                m_cpu_rv, m_aux_rv;
    logic [DATA_W-1:0] m_cpu_rd, m_aux_rd;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, compare mid-cycle, then advance the
    // model across the rising edge. rst_edge is the reset level sampled at
    // the closing edge (differs from rst only for the reset-mid-read case).
    task automatic step(input bit rst, input bit rst_edge,
                        input bit cr, input bit cw, input logic [ADDR_W-1:0] ca,
                        input logic [DATA_W-1:0] cd,
                        input bit ar, input bit aw, input logic [ADDR_W-1:0] aa,
                        input logic [DATA_W-1:0] ad,
                        output bit cg, output bit ag);
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data;
        bit                e_wren;
        logic [DATA_W-1:0] rd_val;

        rst_n         = rst;
        bus.cpu_req   = cr;  bus.cpu_wren = cw;  bus.cpu_addr = ca;  bus.cpu_wdata = cd;
        bus.aux_req   = ar;  bus.aux_wren = aw;  bus.aux_addr = aa;  bus.aux_wdata = ad;

        // Cpu wins unless aux has already been refused MAX_WAIT times in a row.
        cg = 1'b0;
        ag = 1'b0;
        if (rst) begin
            if (ar && m_cnt == MAX_WAIT) ag = 1'b1;
            else if (cr)                 cg = 1'b1;
            else if (ar)                 ag = 1'b1;
        end
        e_addr = cg ? ca : (ag ? aa : '0);
        e_data = cg ? cd : (ag ? ad : '0);
        e_wren = (cg && cw) || (ag && aw);

        #2;
        check("cpu_gnt",      64'(bus.cpu_gnt),      64'(cg));
        check("aux_gnt",      64'(bus.aux_gnt),      64'(ag));
        check("wren",         64'(bus.wren),         64'(e_wren));
        check("address_dmem", 64'(bus.address_dmem), 64'(e_addr));
        check("data",         64'(bus.data),         64'(e_data));
        check("aux_wait_cnt", 64'(aux_wait_cnt),     64'(m_cnt));
        check("cpu_rvalid",   64'(bus.cpu_rvalid),   64'(m_cpu_rv));
        check("aux_rvalid",   64'(bus.aux_rvalid),   64'(m_aux_rv));
        check("cpu_rdata",    64'(bus.cpu_rdata),    64'(m_cpu_rd));
        check("aux_rdata",    64'(bus.aux_rdata),    64'(m_aux_rd));

        rd_val = shadow[e_addr];
        if (e_wren) shadow[e_addr] = e_data;

        if (rst_edge != rst) begin
            #4;
            rst_n = rst_edge;
        end
        @(posedge clk);
        #1;

        if (!rst_edge) begin
            m_cnt    = 0;
            m_cpu_rv = 1'b0;  m_aux_rv = 1'b0;
            m_cpu_rd = '0;    m_aux_rd = '0;
        end else begin
            m_cpu_rv = cg && !cw;
            m_aux_rv = ag && !aw;
            if (m_cpu_rv) m_cpu_rd = rd_val;
            if (m_aux_rv) m_aux_rd = rd_val;
            if (ag || !ar)           m_cnt = 0;
            else if (m_cnt < MAX_WAIT) m_cnt = m_cnt + 1;
        end
    endtask

    initial begin
        bit                cg, ag;
        bit                c_pend, c_w, a_pend, a_w, rst;
        logic [ADDR_W-1:0] c_a, a_a;
        logic [DATA_W-1:0] c_d, a_d;

        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        rst_n = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_wren = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.aux_req = 1'b0; bus.aux_wren = 1'b0; bus.aux_addr = '0; bus.aux_wdata = '0;
        // One unchecked reset edge brings the DUT out of its power-up X state.
        @(posedge clk);
        #1;
        m_cnt = 0; m_cpu_rv = 1'b0; m_aux_rv = 1'b0; m_cpu_rd = '0; m_aux_rd = '0;

        // Reset hold with a pending cpu write, then release.
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 1, 12'h012, 32'hDEADBEEF, 0, 0, '0, '0, cg, ag);
        step(1, 1, 1, 1, 12'h012, 32'hDEADBEEF, 0, 0, '0, '0, cg, ag);
        // Cpu read-back, then idle to observe rvalid.
        step(1, 1, 1, 0, 12'h012, '0, 0, 0, '0, '0, cg, ag);
        step(1, 1, 0, 0, '0, '0, 0, 0, '0, '0, cg, ag);
        // Aux alone.
        step(1, 1, 0, 0, '0, '0, 1, 1, 12'h7FF, 32'h1, cg, ag);
        step(1, 1, 0, 0, '0, '0, 1, 1, 12'h020, 32'hCAFEF00D, cg, ag);
        // Starvation: four denied cycles, forced aux read in the fifth.
        for (int i = 0; i < 5; i++)
            step(1, 1, 1, 0, 12'h012, '0, 1, 0, 12'h020, '0, cg, ag);
        step(1, 1, 1, 0, 12'h012, '0, 0, 0, '0, '0, cg, ag);
        // FORCE abandoned: aux drops its request in the forced cycle.
        for (int i = 0; i < 4; i++)
            step(1, 1, 1, 1, 12'h030, 32'(i), 1, 1, 12'h100, 32'h55, cg, ag);
        step(1, 1, 1, 0, 12'h030, '0, 0, 0, '0, '0, cg, ag);
        step(1, 1, 0, 0, '0, '0, 0, 0, '0, '0, cg, ag);
        // Reset asserted at the edge that ends a granted cpu read.
        step(1, 0, 1, 0, 12'h012, '0, 0, 0, '0, '0, cg, ag);
        step(1, 1, 0, 0, '0, '0, 0, 0, '0, '0, cg, ag);

        // Randomized traffic; requests are held stable until granted.
        c_pend = 1'b0; a_pend = 1'b0;
        c_w = 1'b0; a_w = 1'b0; c_a = '0; a_a = '0; c_d = '0; a_d = '0;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) != 0);
            if (!c_pend) begin
                c_pend = ($urandom_range(0, 99) < 75);
                c_w    = $urandom_range(0, 1) == 1;
                c_a    = ADDR_W'($urandom_range(0, 15));
                c_d    = $urandom;
            end
            if (!a_pend) begin
                a_pend = ($urandom_range(0, 99) < 50);
                a_w    = $urandom_range(0, 1) == 1;
                a_a    = ADDR_W'($urandom_range(0, 15));
                a_d    = $urandom;
            end
            step(rst, rst, c_pend, c_w, c_a, c_d, a_pend, a_w, a_a, a_d, cg, ag);
            if (cg) c_pend = 1'b0;
            if (ag) a_pend = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
